// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and the iterative
// RV32M multiply/divide unit.
//   start, funct3, rs1_data, rs2_data, rd_addr : request from the core (master)
//   busy, done, result, wt_addr, reg_write      : status and register file write port (slave)
interface muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  wt_addr;
  logic        reg_write;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_addr,
    input  busy, done, result, wt_addr, reg_write
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_addr,
    output busy, done, result, wt_addr, reg_write
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit. Works on operand magnitudes
// (shift-add multiply, restoring divide, one bit per cycle) and applies sign
// correction in a final FIX cycle. The result is written back through a one-cycle
// register file write strobe.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : muldiv_if.slave (start/funct3/operands/rd_addr in; busy/done/result/
//          wt_addr/reg_write out)
//   EARLY_OUT : 1 = divide-by-zero completes in one cycle without entering CALC
module muldiv_unit #(
  parameter bit EARLY_OUT = 1'b1
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [4:0]  r_wt_addr;
  logic [31:0] r_a_mag;
  logic [31:0] r_b_mag;
  logic        r_a_neg;
  logic        r_b_neg;
  logic        r_load;   // first CALC cycle seeds the accumulator
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;    // {hi/remainder, lo/quotient}
  logic [31:0] r_result;

  logic        w_accept, w_a_neg, w_b_neg, w_early;
  logic [31:0] w_a_mag, w_b_mag, w_early_result;

  always_comb begin
    w_accept = bus.start && (r_state == StIdle || r_state == StDone);
    w_a_neg  = bus.rs1_data[31] && (bus.funct3 == 3'd1 || bus.funct3 == 3'd2 ||
                                     bus.funct3 == 3'd4 || bus.funct3 == 3'd6);
    w_b_neg  = bus.rs2_data[31] && (bus.funct3 == 3'd1 || bus.funct3 == 3'd4 ||
                                     bus.funct3 == 3'd6);
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude 2^31
    w_a_mag  = w_a_neg ? (32'd0 - bus.rs1_data) : bus.rs1_data;
    w_b_mag  = w_b_neg ? (32'd0 - bus.rs2_data) : bus.rs2_data;
    w_early  = EARLY_OUT && bus.funct3[2] && (bus.rs2_data == 32'd0);
    // funct3[1] separates REM/REMU from DIV/DIVU
    w_early_result = bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF;
  end

  // One iteration of each algorithm
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_trial;
  logic        w_div_ge;
  logic [63:0] w_div_next;

  always_comb begin
    w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b_mag} : 33'd0);
    w_mul_next  = {w_mul_sum, r_acc[31:1]};
    w_div_shift = {r_acc[63:32], r_acc[31]};
    w_div_trial = w_div_shift - {1'b0, r_b_mag};
    // A set top bit means the shifted remainder already exceeds any 32-bit divisor
    w_div_ge    = w_div_shift[32] || !w_div_trial[32];
    w_div_next  = w_div_ge ? {w_div_trial[31:0], r_acc[30:0], 1'b1}
                           : {w_div_shift[31:0], r_acc[30:0], 1'b0};
  end

  // Sign correction and output select
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem, w_a_orig, w_fix_result;
  logic        w_div0;

  always_comb begin
    w_prod   = (r_a_neg ^ r_b_neg) ? (64'd0 - r_acc) : r_acc;
    w_quo    = (r_a_neg ^ r_b_neg) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    w_rem    = r_a_neg ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    w_a_orig = r_a_neg ? (32'd0 - r_a_mag) : r_a_mag;
    w_div0   = (r_b_mag == 32'd0);
    case (r_op)
      3'd0:                w_fix_result = w_prod[31:0];
      3'd1, 3'd2, 3'd3:    w_fix_result = w_prod[63:32];
      3'd4, 3'd5:          w_fix_result = w_div0 ? 32'hFFFF_FFFF : w_quo;
      default:             w_fix_result = w_div0 ? w_a_orig : w_rem;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = w_early ? StDone : StCalc;
      StCalc:  if (!r_load && r_cnt == 5'd31) w_state_next = StFix;
      StFix:   w_state_next = StDone;
      StDone:  w_state_next = w_accept ? (w_early ? StDone : StCalc) : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy      = (r_state == StCalc) || (r_state == StFix);
    bus.done      = (r_state == StDone);
    bus.reg_write = (r_state == StDone) && (r_wt_addr != 5'd0);
    bus.result    = r_result;
    bus.wt_addr   = r_wt_addr;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= 3'd0;
      r_rd      <= 5'd0;
      r_wt_addr <= 5'd0;
      r_a_mag   <= 32'd0;
      r_b_mag   <= 32'd0;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_load    <= 1'b0;
      r_cnt     <= 5'd0;
      r_acc     <= 64'd0;
      r_result  <= 32'd0;
    end else if (w_accept) begin
      r_op    <= bus.funct3;
      r_rd    <= bus.rd_addr;
      r_a_mag <= w_a_mag;
      r_b_mag <= w_b_mag;
      r_a_neg <= w_a_neg;
      r_b_neg <= w_b_neg;
      r_load  <= 1'b1;
      r_cnt   <= 5'd0;
      if (w_early) begin
        r_result  <= w_early_result;
        r_wt_addr <= bus.rd_addr;
      end
    end else if (r_state == StCalc) begin
      if (r_load) begin
        // Both algorithms start from {0, operand A}
        r_acc  <= {32'd0, r_a_mag};
        r_load <= 1'b0;
      end else begin
        r_acc <= r_op[2] ? w_div_next : w_mul_next;
        r_cnt <= r_cnt + 5'd1;
      end
    end else if (r_state == StFix) begin
      r_result  <= w_fix_result;
      r_wt_addr <= r_rd;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  muldiv_if bus ();

  muldiv_unit #(.EARLY_OUT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lat;        // posedges after the accepting edge until done seen; -1 = timeout
    int          busy_cnt;   // samples with busy high up to and including the done sample
    logic [31:0] res;
    logic [4:0]  wa;
    logic        rw;
    logic [31:0] res_after;
    logic        done_after;
  } obs_t;

  // Reference model: RV32M semantics with plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sq;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sq = sa / sb; return sq[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sq = sa % sb; return sq[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_addr  = rd;
  endtask

  // Start must already be driven; observes one operation from its accepting edge.
  task automatic run_op(input bit poke, input bit chain, input logic [2:0] nf3,
                        input logic [31:0] na, input logic [31:0] nb, input logic [4:0] nrd,
                        output obs_t o);
    o.lat = -1; o.busy_cnt = 0; o.res = '0; o.wa = '0; o.rw = 1'b0;
    o.res_after = '0; o.done_after = 1'b0;
    @(posedge clk);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (poke && k == 10) begin
        bus.start    = 1'b1;
        bus.funct3   = 3'($urandom);
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
      end
      if (poke && k == 11) bus.start = 1'b0;
      if (bus.busy === 1'b1) o.busy_cnt++;
      if (bus.done === 1'b1) begin
        o.lat = k; o.res = bus.result; o.wa = bus.wt_addr; o.rw = bus.reg_write;
        if (chain) drive(nf3, na, nb, nrd);
        break;
      end
    end
    if (o.lat >= 0 && !chain) begin
      @(negedge clk);
      o.res_after  = bus.result;
      o.done_after = bus.done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.funct3 = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_addr = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.reg_write} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.reg_write});
    end
    checks++;
    if (bus.result !== 32'd0 || bus.wt_addr !== 5'd0) begin
      errors++; $display("FAIL reset_data got %h/%0d want 0/0", bus.result, bus.wt_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [2:0]  d_f3  [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6,
                              3'd4, 3'd6, 3'd5, 3'd7};
  logic [31:0] d_a   [14] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                              32'hFFFFFFF9, 32'd100, 32'd100, 32'h1234, 32'h1234,
                              32'h80000000, 32'h80000000, 32'h55, 32'h55};
  logic [31:0] d_b   [14] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd0, 32'd0};
  logic [31:0] d_exp [14] = '{32'hFFFFFFEB, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                              32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'h1234,
                              32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h55};
  int          d_lat [14] = '{34, 34, 34, 34, 34, 34, 34, 34, 0, 0, 34, 34, 0, 0};

  task automatic test_directed();
    obs_t o;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(d_f3[i], d_a[i], d_b[i], 5'd5);
      run_op(1'b0, 1'b0, '0, '0, '0, '0, o);
      checks++;
      if (o.lat != d_lat[i]) begin
        errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, o.lat, d_lat[i]);
      end
      checks++;
      if (o.res !== d_exp[i]) begin
        errors++; $display("FAIL dir%0d_result got %h want %h", i, o.res, d_exp[i]);
      end
      checks++;
      if (o.wa !== 5'd5 || o.rw !== 1'b1) begin
        errors++; $display("FAIL dir%0d_write got %0d/%b want 5/1", i, o.wa, o.rw);
      end
      checks++;
      if (o.busy_cnt != d_lat[i]) begin
        errors++; $display("FAIL dir%0d_busy got %0d want %0d", i, o.busy_cnt, d_lat[i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    obs_t o;
    int   wr_seen;
    @(negedge clk);
    drive(3'd4, 32'd1000, 32'd3, 5'd9);
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.reg_write} !== 3'b000 || bus.result !== 32'd0 ||
        bus.wt_addr !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs got busy=%b done=%b rw=%b res=%h wa=%0d want all 0",
               bus.busy, bus.done, bus.reg_write, bus.result, bus.wt_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    wr_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.reg_write !== 1'b0 || bus.busy !== 1'b0) wr_seen++;
    end
    checks++;
    if (wr_seen != 0) begin
      errors++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", wr_seen);
    end
    // MUL 3 x 4 to x0 with stray start pulses during CALC
    drive(3'd0, 32'd3, 32'd4, 5'd0);
    run_op(1'b1, 1'b0, '0, '0, '0, '0, o);
    checks++;
    if (o.lat != 34) begin
      errors++; $display("FAIL rd0_latency got %0d want 34", o.lat);
    end
    checks++;
    if (o.res !== 32'd12 || o.rw !== 1'b0 || o.wa !== 5'd0) begin
      errors++; $display("FAIL rd0_result got %h/rw=%b want 0000000c/rw=0", o.res, o.rw);
    end
    checks++;
    if (o.done_after !== 1'b0 || o.res_after !== 32'd12) begin
      errors++; $display("FAIL rd0_idle got done=%b res=%h want 0/0000000c",
                         o.done_after, o.res_after);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    @(negedge clk);
    drive(3'd5, 32'd1000, 32'd7, 5'd3);
    run_op(1'b0, 1'b1, 3'd1, 32'hFFFF0000, 32'h00020000, 5'd4, o1);
    run_op(1'b0, 1'b0, '0, '0, '0, '0, o2);
    checks++;
    if (o1.lat != 34 || o1.res !== 32'd142 || o1.rw !== 1'b1 || o1.wa !== 5'd3) begin
      errors++; $display("FAIL b2b_first got lat=%0d res=%h rw=%b wa=%0d want 34/0000008e/1/3",
                         o1.lat, o1.res, o1.rw, o1.wa);
    end
    checks++;
    if (o2.lat != 34 || o2.busy_cnt != 34) begin
      errors++; $display("FAIL b2b_second_timing got lat=%0d busy=%0d want 34/34",
                         o2.lat, o2.busy_cnt);
    end
    checks++;
    if (o2.res !== 32'hFFFFFFFE || o2.rw !== 1'b1 || o2.wa !== 5'd4) begin
      errors++; $display("FAIL b2b_second got res=%h rw=%b wa=%0d want fffffffe/1/4",
                         o2.res, o2.rw, o2.wa);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    obs_t        o;
    logic [2:0]  f3;
    logic [31:0] a, b, exp_res;
    logic [4:0]  rd;
    int          exp_lat;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom); a = pick_operand(); b = pick_operand(); rd = 5'($urandom);
      exp_res = ref_model(f3, a, b);
      exp_lat = (f3[2] && b == 32'd0) ? 0 : 34;
      @(negedge clk);
      drive(f3, a, b, rd);
      run_op(i % 7 == 3, 1'b0, '0, '0, '0, '0, o);
      checks++;
      if (o.lat != exp_lat || o.busy_cnt != exp_lat) begin
        errors++; $display("FAIL rnd%0d_timing f3=%0d got lat=%0d busy=%0d want %0d",
                           i, f3, o.lat, o.busy_cnt, exp_lat);
      end
      checks++;
      if (o.res !== exp_res) begin
        errors++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h got %h want %h",
                           i, f3, a, b, o.res, exp_res);
      end
      checks++;
      if (o.wa !== rd || o.rw !== (rd != 5'd0)) begin
        errors++; $display("FAIL rnd%0d_write got wa=%0d rw=%b want wa=%0d rw=%b",
                           i, o.wa, o.rw, rd, rd != 5'd0);
      end
      checks++;
      if (o.done_after !== 1'b0 || o.res_after !== exp_res) begin
        errors++; $display("FAIL rnd%0d_hold got done=%b res=%h want 0/%h",
                           i, o.done_after, o.res_after, exp_res);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
